img_stream_tx: RTL and testbench
================================

Name: img_stream_tx

Overview:
- Byte-stream source that drives the 8-bit iDVAL/iDATA input of the guided-filter pipeline. It replays an image held in a 24-bit synchronous ROM/RAM as a serial byte stream.
- Uses the same one-shot ena / done handshake as the pipeline stages, so a top-level flow controller or testbench can trigger and sequence it.
- Each 24-bit word is emitted MSB byte first. Words are prefetched so back-to-back streaming has no bubbles.

Parameters:
WORDS, 16384, number of 24-bit words per frame (1..65536); addresses 0..WORDS-1
GAP, 0, idle cycles with oDVAL=0 inserted after every emitted byte (0..255)

Ports:
iCLK  input  1  clock; all state updates on rising edge
iRST_N  input  1  reset, asynchronous, active-low
ena  input  1  start pulse; sampled only in IDLE
done  output  1  one-cycle pulse after the last byte of the frame
iHOLD  input  1  flow control; while high, no new byte is issued
oAddr  output  16  word address to the source memory (registered)
iRdData  input  24  memory read data; valid 1 cycle after oAddr changes (registered-address memory)
oDVAL  output  1  byte valid, exactly one cycle per byte
oDATA  output  8  byte value; 0 whenever oDVAL=0

Behaviour:
- Reset (async, iRST_N=0): state=IDLE, oAddr=0, oDVAL=0, oDATA=0, done=0, word counter=0, byte index=0, gap counter=0, shift register=0. Any frame in progress is abandoned; no done is issued for it.
- States:
  - IDLE: waits for ena.
  - PRIME: waits one memory latency cycle.
  - STREAM: emits bytes.
  - FIN: pulses done.
- IDLE: at an edge with ena=1: oAddr<=0, go to PRIME. ena=0 keeps IDLE.
- PRIME: after one edge, go to STREAM. iRdData for address 0 is valid at the next edge.
- STREAM, issue condition: at an edge a byte is issued iff gap counter=0 and iHOLD=0. Otherwise oDVAL<=0, oDATA<=0, and the gap counter decrements if it is non-zero.
- STREAM, byte 0 of word k: shift register<=iRdData, oDATA<=iRdData[23:16], oDVAL<=1. If k<WORDS-1, oAddr<=k+1 (prefetch).
- STREAM, bytes 1 and 2: oDATA<=shift[15:8], then shift[7:0], with oDVAL<=1 each time.
- After every issued byte, gap counter<=GAP.
- Memory contract: oAddr changes only on a byte-0 issue, so iRdData stays stable through any hold or gap.
- Frame end: after byte 2 of word WORDS-1, the next edge drives oDVAL<=0 and done<=1, and state goes to FIN. The GAP after the last byte is not honoured; done follows immediately.
- FIN: at the next edge: done<=0, oAddr<=0, state<=IDLE.
- Latency (GAP=0, iHOLD=0): ena sampled at edge E0 → first oDVAL high after E2. oDVAL then stays high for exactly 3*WORDS consecutive cycles. done is high in the cycle right after the last oDVAL cycle.
- ena while not in IDLE: ignored, with no restart and no queueing. ena in the same cycle as done (FIN): ignored. ena one cycle later (IDLE): accepted.
- iHOLD is honoured on every byte, including the first byte of the frame. Holding for N cycles delays the stream by exactly N cycles with no loss or duplication.
- Counters:
  - word counter is 17 bits, so WORDS=65536 works without wrap.
  - oAddr is never driven ≥ WORDS.
  - byte index wraps 2→0.
- done is never asserted except at the true frame end.

Test Plan:
- Basic stream: WORDS=4, GAP=0, ROM[0..3]=0x112233, 0x445566, 0x778899, 0xAABBCC; pulse ena → oDATA 11,22,33,44,55,66,77,88,99,AA,BB,CC. oDVAL high for 12 contiguous cycles starting 2 cycles after the ena edge. done is a single pulse on the next cycle. oAddr returns to 0.
- Gap insertion: same ROM, GAP=2 → each byte is followed by exactly 2 cycles of oDVAL=0, oDATA=0. Same byte order. done comes 1 cycle after the last byte.
- Backpressure: GAP=0; iHOLD high for 5 cycles at the byte-1 slot of word 2, and high for 3 cycles just before the first byte → no bytes lost or duplicated. Total frame length is 12+8 cycles after the first issue opportunity. oAddr stable during holds.
- Ignored start: pulse ena again mid-frame and during the done cycle → stream unaffected, only one done. A new ena after return to IDLE replays the frame from address 0.
- Async reset mid-frame: deassert iRST_N between clock edges after byte 5 → outputs go to 0 immediately, no done. Release reset and pulse ena → full 12-byte frame from 0x11.
- Boundary: WORDS=1, ROM[0]=0xFF00A5 → exactly 3 bytes FF,00,A5, then done. oAddr stays 0 throughout (no prefetch beyond WORDS-1).

Source files
------------

// File: rtl/img_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : img_stream_tx
// Description : Replays a frame of 24-bit words from a registered-address
//               memory as a serial byte stream (MSB byte first) with a
//               one-shot ena/done handshake, optional inter-byte gap and
//               iHOLD flow control. The next word is prefetched while the
//               current word's lower bytes go out, so streaming has no bubbles.
// Revision    : 1.0 - initial release
// ============================================================================
module img_stream_tx #(
    parameter int WORDS = 16384,   // words per frame, 1..65536
    parameter int GAP   = 0        // idle cycles after each byte, 0..255
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        ena,
    output logic        done,
    input  logic        iHOLD,
    output logic [15:0] oAddr,
    input  logic [23:0] iRdData,
    output logic        oDVAL,
    output logic [7:0]  oDATA
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PRIME  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;
    localparam logic [1:0] S_FIN    = 2'd3;

    // 17-bit word count so a full 65536-word frame terminates without wrap.
    localparam logic [16:0] C_WORDS = 17'(WORDS);
    localparam logic [16:0] C_LAST  = 17'(WORDS - 1);
    localparam logic [7:0]  C_GAP   = 8'(GAP);

    logic [1:0]  state_q, state_d;
    logic [15:0] addr_q,  addr_d;
    logic        dval_q,  dval_d;
    logic [7:0]  data_q,  data_d;
    logic        done_q,  done_d;
    logic [16:0] word_q,  word_d;
    logic [1:0]  byte_q,  byte_d;
    logic [7:0]  gap_q,   gap_d;
    // The top byte goes straight from iRdData to oDATA, so only the two
    // lower bytes of the word need to be kept for bytes 1 and 2.
    logic [15:0] shift_q, shift_d;

    logic        issue;

    assign issue = (gap_q == 8'd0) && !iHOLD;

    // Next-state logic for the frame sequencer and byte serializer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        dval_d  = dval_q;
        data_d  = data_q;
        done_d  = done_q;
        word_d  = word_q;
        byte_d  = byte_q;
        gap_d   = gap_q;
        shift_d = shift_q;

        case (state_q)
            S_IDLE: begin
                if (ena) begin
                    addr_d  = 16'd0;
                    word_d  = 17'd0;
                    byte_d  = 2'd0;
                    gap_d   = 8'd0;
                    state_d = S_PRIME;
                end
            end

            // Memory needs one edge to present word 0 on iRdData.
            S_PRIME: begin
                state_d = S_STREAM;
            end

            S_STREAM: begin
                if (word_q == C_WORDS) begin
                    // Last byte already issued: the trailing gap is skipped.
                    dval_d  = 1'b0;
                    data_d  = 8'd0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (issue) begin
                    dval_d = 1'b1;
                    gap_d  = C_GAP;
                    case (byte_q)
                        2'd0: begin
                            shift_d = iRdData[15:0];
                            data_d  = iRdData[23:16];
                            byte_d  = 2'd1;
                            // Prefetch the next word; never address past the frame.
                            if (word_q < C_LAST) begin
                                addr_d = word_q[15:0] + 16'd1;
                            end
                        end
                        2'd1: begin
                            data_d = shift_q[15:8];
                            byte_d = 2'd2;
                        end
                        default: begin
                            data_d = shift_q[7:0];
                            byte_d = 2'd0;
                            word_d = word_q + 17'd1;
                        end
                    endcase
                end else begin
                    dval_d = 1'b0;
                    data_d = 8'd0;
                    if (gap_q != 8'd0) begin
                        gap_d = gap_q - 8'd1;
                    end
                end
            end

            S_FIN: begin
                done_d  = 1'b0;
                addr_d  = 16'd0;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any frame in progress without a done.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q <= S_IDLE;
            addr_q  <= 16'd0;
            dval_q  <= 1'b0;
            data_q  <= 8'd0;
            done_q  <= 1'b0;
            word_q  <= 17'd0;
            byte_q  <= 2'd0;
            gap_q   <= 8'd0;
            shift_q <= 16'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            dval_q  <= dval_d;
            data_q  <= data_d;
            done_q  <= done_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            gap_q   <= gap_d;
            shift_q <= shift_d;
        end
    end

    assign oAddr = addr_q;
    assign oDVAL = dval_q;
    assign oDATA = data_q;
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_img_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_img_stream_tx
// Description : Directed bench for img_stream_tx. Three instances cover
//               WORDS=4/GAP=0, WORDS=4/GAP=2 and WORDS=1/GAP=0, each fed by
//               its own registered-address ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_img_stream_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        ena_a, hold_a, done_a, dval_a;
    logic [15:0] addr_a;
    logic [23:0] rd_a;
    logic [7:0]  data_a;

    logic        ena_b, hold_b, done_b, dval_b;
    logic [15:0] addr_b;
    logic [23:0] rd_b;
    logic [7:0]  data_b;

    logic        ena_c, hold_c, done_c, dval_c;
    logic [15:0] addr_c;
    logic [23:0] rd_c;
    logic [7:0]  data_c;

    int total = 0;
    int bad   = 0;

    logic [23:0] rom4 [4] = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    logic [7:0]  seq4 [12] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                               8'h77, 8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [7:0]  seq1 [3]  = '{8'hFF, 8'h00, 8'hA5};

    img_stream_tx #(.WORDS(4), .GAP(0)) u_a (
        .iCLK(clk), .iRST_N(rst_n), .ena(ena_a), .done(done_a), .iHOLD(hold_a),
        .oAddr(addr_a), .iRdData(rd_a), .oDVAL(dval_a), .oDATA(data_a)
    );

    img_stream_tx #(.WORDS(4), .GAP(2)) u_b (
        .iCLK(clk), .iRST_N(rst_n), .ena(ena_b), .done(done_b), .iHOLD(hold_b),
        .oAddr(addr_b), .iRdData(rd_b), .oDVAL(dval_b), .oDATA(data_b)
    );

    img_stream_tx #(.WORDS(1), .GAP(0)) u_c (
        .iCLK(clk), .iRST_N(rst_n), .ena(ena_c), .done(done_c), .iHOLD(hold_c),
        .oAddr(addr_c), .iRdData(rd_c), .oDVAL(dval_c), .oDATA(data_c)
    );

    // Registered-address memories: data valid one edge after the address.
    always @(posedge clk) begin
        rd_a <= rom4[addr_a[1:0]];
        rd_b <= rom4[addr_b[1:0]];
        rd_c <= (addr_c == 16'd0) ? 24'hFF00A5 : 24'h5A5A5A;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic e, input logic h);
        case (sel)
            0:       begin ena_a = e; hold_a = h; end
            1:       begin ena_b = e; hold_b = h; end
            default: begin ena_c = e; hold_c = h; end
        endcase
    endtask

    task automatic get_out(input int sel, output logic dv, output logic [7:0] d,
                           output logic dn, output logic [15:0] a);
        case (sel)
            0:       begin dv = dval_a; d = data_a; dn = done_a; a = addr_a; end
            1:       begin dv = dval_b; d = data_b; dn = done_b; a = addr_b; end
            default: begin dv = dval_c; d = data_c; dn = done_c; a = addr_c; end
        endcase
    endtask

    function automatic logic [7:0] seqv(input int sel, input int i);
        return (sel == 2) ? seq1[i] : seq4[i];
    endfunction

    // One frame, cycle by cycle. Edge 0 samples ena; hold windows are given
    // as [start, start+len) in edge numbers. poke_e re-pulses ena mid-frame,
    // poke_done pulses ena during the done cycle, abort_e stops early.
    task automatic run_frame(input int sel, input int hs0, input int hn0,
                             input int hs1, input int hn1, input int poke_e,
                             input bit poke_done, input int abort_e);
        int          words, gap, nb, idx, gapc;
        logic [15:0] aexp;
        logic        h, edv, edn, fin;
        logic [7:0]  ed;
        logic        dv, dn;
        logic [7:0]  d;
        logic [15:0] a;
        words = (sel == 2) ? 1 : 4;
        gap   = (sel == 1) ? 2 : 0;
        nb    = 3 * words;
        idx   = 0;
        gapc  = 0;
        aexp  = 16'd0;
        fin   = 1'b0;
        for (int e = 0; e < 400; e++) begin
            h = ((e >= hs0) && (e < hs0 + hn0)) || ((e >= hs1) && (e < hs1 + hn1));
            set_in(sel, (e == 0) || (e == poke_e), h);
            @(negedge clk);
            edv = 1'b0; ed = 8'd0; edn = 1'b0;
            if (e >= 2) begin
                if (idx == nb) begin
                    edn = 1'b1;
                    fin = 1'b1;
                end else if (gapc == 0 && !h) begin
                    edv = 1'b1;
                    ed  = seqv(sel, idx);
                    if ((idx % 3 == 0) && (idx / 3 < words - 1)) aexp = 16'(idx / 3 + 1);
                    idx++;
                    gapc = gap;
                end else if (gapc != 0) begin
                    gapc--;
                end
            end
            get_out(sel, dv, d, dn, a);
            chk($sformatf("dval s%0d e%0d", sel, e), 32'(dv), 32'(edv));
            chk($sformatf("data s%0d e%0d", sel, e), 32'(d), 32'(ed));
            chk($sformatf("done s%0d e%0d", sel, e), 32'(dn), 32'(edn));
            chk($sformatf("addr s%0d e%0d", sel, e), 32'(a), 32'(aexp));
            if (e == abort_e) begin
                set_in(sel, 1'b0, 1'b0);
                return;
            end
            if (fin) break;
        end
        // FIN edge: done drops, address returns to 0; ena here must be ignored.
        set_in(sel, poke_done, 1'b0);
        @(negedge clk);
        set_in(sel, 1'b0, 1'b0);
        get_out(sel, dv, d, dn, a);
        chk($sformatf("fin done s%0d", sel), 32'(dn), 32'd0);
        chk($sformatf("fin addr s%0d", sel), 32'(a), 32'd0);
        chk($sformatf("fin dval s%0d", sel), 32'(dv), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            get_out(sel, dv, d, dn, a);
            chk($sformatf("idle dval s%0d k%0d", sel, k), 32'(dv), 32'd0);
            chk($sformatf("idle done s%0d k%0d", sel, k), 32'(dn), 32'd0);
        end
    endtask

    initial begin
        logic        dv, dn;
        logic [7:0]  d;
        logic [15:0] a;

        rst_n = 1'b0;
        ena_a = 1'b0; hold_a = 1'b0;
        ena_b = 1'b0; hold_b = 1'b0;
        ena_c = 1'b0; hold_c = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of every instance.
        for (int s = 0; s < 3; s++) begin
            get_out(s, dv, d, dn, a);
            chk($sformatf("rst dval s%0d", s), 32'(dv), 32'd0);
            chk($sformatf("rst data s%0d", s), 32'(d),  32'd0);
            chk($sformatf("rst done s%0d", s), 32'(dn), 32'd0);
            chk($sformatf("rst addr s%0d", s), 32'(a),  32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Basic stream.
        run_frame(0, -1, 0, -1, 0, -1, 1'b0, -1);
        // Gap insertion.
        run_frame(1, -1, 0, -1, 0, -1, 1'b0, -1);
        // Backpressure: 3 cycles before byte 0, 5 cycles at word 2 byte 1.
        run_frame(0, 2, 3, 12, 5, -1, 1'b0, -1);
        // Ignored start mid-frame and during done, then a clean replay.
        run_frame(0, -1, 0, -1, 0, 6, 1'b1, -1);
        run_frame(0, -1, 0, -1, 0, -1, 1'b0, -1);

        // Async reset after byte 5 (0x66 issued at edge 7).
        run_frame(0, -1, 0, -1, 0, -1, 1'b0, 7);
        #2 rst_n = 1'b0;
        #1;
        chk("arst dval", 32'(dval_a), 32'd0);
        chk("arst data", 32'(data_a), 32'd0);
        chk("arst addr", 32'(addr_a), 32'd0);
        chk("arst done", 32'(done_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk($sformatf("post-rst done k%0d", k), 32'(done_a), 32'd0);
            chk($sformatf("post-rst dval k%0d", k), 32'(dval_a), 32'd0);
        end
        run_frame(0, -1, 0, -1, 0, -1, 1'b0, -1);

        // Single-word frame: no prefetch beyond word 0.
        run_frame(2, -1, 0, -1, 0, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
